// File: rtl/pc_npc_unit.sv
// pc_npc_unit: PC/nPC pair for a delayed-branch fetch stage with trap redirect, one-cycle flush and optional PC history (PC_HIST_EN)
// Ports: clk, reset_n (async active-low); le advance enable; br_taken/br_target delayed branch;
// annul_req annuls the instruction entering pc; trap_req/trap_vec trap redirect; hist_idx history index;
// pc/npc fetch addresses; annul_q squash flag for pc; flush high in TRAP_HOLD; hist_data selected history entry.
module pc_npc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] INC = WIDTH'(4),
  parameter int HIST_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          le,
  input  logic                          br_taken,
  input  logic [WIDTH-1:0]              br_target,
  input  logic                          annul_req,
  input  logic                          trap_req,
  input  logic [WIDTH-1:0]              trap_vec,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [WIDTH-1:0]              pc,
  output logic [WIDTH-1:0]              npc,
  output logic                          annul_q,
  output logic                          flush,
  output logic [WIDTH-1:0]              hist_data
);
  localparam int HW = $clog2(HIST_DEPTH);
  typedef enum logic {RUN, TRAP_HOLD} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] pc_d, npc_d;
  logic annul_d, rec;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      pc      <= RESET_PC;
      npc     <= RESET_PC + INC;
      annul_q <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      npc     <= npc_d;
      annul_q <= annul_d;
    end
  end
  always_comb begin
    state_d = RUN;
    pc_d    = pc;
    npc_d   = npc;
    annul_d = annul_q;
    rec     = 1'b0;
    if (state == RUN && trap_req) begin
      state_d = TRAP_HOLD;
      pc_d    = trap_vec;
      npc_d   = trap_vec + INC;
      annul_d = 1'b0;
      rec     = 1'b1;
    end else if (state == RUN && le) begin
      pc_d    = npc;
      npc_d   = br_taken ? br_target : npc + INC;
      annul_d = annul_req;
      rec     = 1'b1;
    end
  end
  assign flush = (state == TRAP_HOLD);
`ifdef PC_HIST_EN
  logic [WIDTH-1:0] hist [HIST_DEPTH];
  logic [HW-1:0] wptr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else if (rec) begin
      hist[wptr] <= pc;
      wptr       <= wptr + HW'(1);
    end
  end
  // wptr points at the next free slot, so the newest entry sits one behind it
  assign hist_data = hist[wptr - HW'(1) - hist_idx];
`else
  logic unused_hist;
  assign unused_hist = ^{hist_idx, rec};
  assign hist_data   = '0;
`endif
endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- Parametrised program-counter pair (PC/nPC) for the delayed-branch fetch stage. Generalises the single nPC register.
- Holds PC and nPC together, with programmable width, reset vector and increment.
- Handles taken delayed branches, delay-slot annulment, and trap redirection with a one-cycle flush state.
- Sits between the branch/trap resolution logic and the instruction-memory address port.

Parameters:
- WIDTH, 32, width of PC/nPC and all address ports.
- RESET_PC, 0, PC value after reset. nPC resets to RESET_PC+INC.
- INC, 4, sequential increment added to nPC, modulo 2^WIDTH.
- HIST_DEPTH, 4, entries in the PC history buffer (power of two, ≥2). Used only with PC_HIST_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- le  in  1  advance enable. 0 = stall, holds PC/nPC/annul_q.
- br_taken  in  1  delayed branch resolved taken this cycle.
- br_target  in  WIDTH  branch target address.
- annul_req  in  1  annul the instruction that enters PC on this advance (the delay slot).
- trap_req  in  1  trap request, level-sampled.
- trap_vec  in  WIDTH  trap handler address.
- hist_idx  in  clog2(HIST_DEPTH)  history read index; 0 = most recent.
- pc  out  WIDTH  current fetch address.
- npc  out  WIDTH  next fetch address.
- annul_q  out  1  instruction at pc is annulled; downstream must squash it.
- flush  out  1  high during TRAP_HOLD; pipeline must discard in-flight instructions.
- hist_data  out  WIDTH  history entry selected by hist_idx.

Behaviour:
- Reset (reset_n=0, asynchronous, any cycle including TRAP_HOLD):
  - pc=RESET_PC, npc=RESET_PC+INC, annul_q=0, flush=0, state=RUN.
  - History pointer=0, history entries=0.
- States: RUN, TRAP_HOLD. flush=1 exactly when state=TRAP_HOLD (registered, not combinational from trap_req).
- RUN, per-edge priority: trap_req > !le > br_taken > sequential.
  - trap_req=1, taken regardless of le:
    - pc<=trap_vec, npc<=trap_vec+INC, annul_q<=0, state<=TRAP_HOLD.
    - br_taken and annul_req are ignored.
  - le=0: all state held; annul_q held.
  - le=1, br_taken=1: pc<=npc, npc<=br_target, annul_q<=annul_req.
  - le=1, br_taken=0: pc<=npc, npc<=npc+INC, annul_q<=annul_req (annul of an untaken branch's delay slot).
- TRAP_HOLD: lasts exactly one cycle.
  - pc, npc and annul_q are held.
  - trap_req, br_taken and annul_req are ignored.
  - Next state is RUN unconditionally. le does not extend TRAP_HOLD.
- Arithmetic:
  - All additions are WIDTH bits and wrap modulo 2^WIDTH. Example: npc=2^WIDTH−INC advances to 0.
  - No alignment checking; addresses are passed through unmodified.
- Latency: every update is visible on pc/npc one cycle after the sampling edge. No combinational path from inputs to pc, npc, annul_q or flush.
- Simultaneous events:
  - trap_req with le=0 still redirects.
  - br_taken with le=0 is lost; the branch unit must hold it until le=1.

Optional Feature:
- Macro PC_HIST_EN.
- Defined:
  - HIST_DEPTH-entry circular buffer of retired PCs.
  - On every advance (RUN, le=1, no trap), the outgoing pc is written at the write pointer and the pointer increments, wrapping at HIST_DEPTH.
  - Traps also record the outgoing pc.
  - hist_data = entry written hist_idx+1 advances ago, combinational read.
  - Unwritten entries read 0.
- Undefined: no buffer storage; hist_data tied to 0; hist_idx ignored.

Test Plan:
- Reset: WIDTH=32, RESET_PC=0, INC=4. Release reset_n → pc=0, npc=4, annul_q=0, flush=0. Assert reset_n=0 mid-cycle → outputs return to reset values immediately, without waiting for a clock edge.
- Sequential with stall: 3 edges with le=1, then 2 with le=0 → pc sequence 4, 8, 12, 12, 12; npc ends at 16.
- Delayed branch with annul:
  - From pc=8/npc=12, drive br_taken=1, br_target=0x100, annul_req=1 → pc=12, npc=0x100, annul_q=1.
  - Next advance → pc=0x100, npc=0x104, annul_q=0.
- Trap during stall:
  - le=0, trap_req=1, trap_vec=0x80 → next cycle pc=0x80, npc=0x84, flush=1.
  - Following cycle, with trap_req still 1 → flush=0, pc unchanged.
  - Next edge (RUN, trap_req still 1) → second redirect to 0x80.
- Wrap: WIDTH=8, RESET_PC=0xF8, INC=4 → pc sequence 0xF8, 0xFC, 0x00, 0x04.
- PC_HIST_EN: 5 advances from reset → hist_idx=0 reads 16, hist_idx=3 reads 4. Without the macro → hist_data=0.
